// File: rtl/seg_xlat_pipe.sv
// Segment/EMS translation stage: registers a CPU request, looks up its page in the
// mapper, and queues the 21-bit physical request for the SDRAM/cache controller.
module seg_xlat_pipe #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [19:0]       req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [5:0]        memaddr,
    input  logic [6:0]        memdata,
    input  logic              map_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [20:0]       out_addr,
    output logic              out_ems,
    output logic              out_we,
    output logic [1:0]        out_be,
    output logic [DATA_W-1:0] out_wdata,
    output logic [3:0]        occupancy
);
    localparam int         PTR_W   = $clog2(OUT_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(OUT_DEPTH);

    function automatic logic [20:0] phys_addr(input logic [6:0] page, input logic [13:0] offset);
        return {page, offset};
    endfunction

    logic              vld_p1;
    logic [19:0]       addr_p1;
    logic              we_p1;
    logic [1:0]        be_p1;
    logic [DATA_W-1:0] wdata_p1;

    logic [20:0]       addr_mem  [OUT_DEPTH];
    logic              ems_mem   [OUT_DEPTH];
    logic              we_mem    [OUT_DEPTH];
    logic [1:0]        be_mem    [OUT_DEPTH];
    logic [DATA_W-1:0] wdata_mem [OUT_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        count;

    logic pop;
    logic space;
    logic adv;
    logic accept;

    assign memaddr   = addr_p1[19:14];
    assign out_valid = (count != 4'd0);
    assign pop       = out_valid & out_ready;
    assign space     = (count < DEPTH_C) | pop;
    // A map write may change memdata at the next edge, so the lookup is retried.
    assign adv       = vld_p1 & ~map_wr & space;
    assign req_ready = ~vld_p1 | adv;
    assign accept    = req_valid & req_ready;
    assign occupancy = count;

    assign out_addr  = addr_mem[rd_ptr];
    assign out_ems   = ems_mem[rd_ptr];
    assign out_we    = we_mem[rd_ptr];
    assign out_be    = be_mem[rd_ptr];
    assign out_wdata = wdata_mem[rd_ptr];

    // Stage p1: registered request awaiting translation
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_p1  <= req_addr;
            we_p1    <= req_we;
            be_p1    <= req_be;
            wdata_p1 <= req_wdata;
        end
    end

    // Stage out: translated request FIFO
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (adv) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({adv, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (adv) begin
            addr_mem[wr_ptr]  <= phys_addr(memdata, addr_p1[13:0]);
            ems_mem[wr_ptr]   <= memdata[6];
            we_mem[wr_ptr]    <= we_p1;
            be_mem[wr_ptr]    <= be_p1;
            wdata_mem[wr_ptr] <= wdata_p1;
        end
    end

endmodule

// File: tb/tb_seg_xlat_pipe.sv
// Bench for seg_xlat_pipe: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based transaction model of the translator.
module tb_seg_xlat_pipe;
    localparam int DATA_W    = 16;
    localparam int OUT_DEPTH = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              req_valid;
    logic              req_ready;
    logic [19:0]       req_addr;
    logic              req_we;
    logic [1:0]        req_be;
    logic [DATA_W-1:0] req_wdata;
    logic [5:0]        memaddr;
    logic [6:0]        memdata;
    logic              map_wr;
    logic              out_valid;
    logic              out_ready;
    logic [20:0]       out_addr;
    logic              out_ems;
    logic              out_we;
    logic [1:0]        out_be;
    logic [DATA_W-1:0] out_wdata;
    logic [3:0]        occupancy;

    always #5 CLK = ~CLK;

    seg_xlat_pipe #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .memaddr(memaddr), .memdata(memdata), .map_wr(map_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_ems(out_ems), .out_we(out_we), .out_be(out_be), .out_wdata(out_wdata),
        .occupancy(occupancy)
    );

    // Mapper model: combinational lookup, entries change only at an edge ending a map_wr cycle
    logic [6:0] map [64];
    assign memdata = map[memaddr];
    logic       map_chg;
    int         chg_idx;
    logic [6:0] chg_val;

    typedef struct packed {
        logic [19:0]       addr;
        logic              we;
        logic [1:0]        be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [20:0]       addr;
        logic              ems;
        logic              we;
        logic [1:0]        be;
        logic [DATA_W-1:0] wdata;
    } ent_t;

    req_t        s1_q[$];
    ent_t        out_q[$];
    logic [20:0] seen[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle with the inputs already driven; returns whether the request was taken.
    task automatic step(output bit acc);
        bit   mrdy, pop, space, adv;
        ent_t e;
        req_t r;
        @(negedge CLK);
        pop   = (out_q.size() > 0) && out_ready;
        space = (out_q.size() < OUT_DEPTH) || pop;
        adv   = (s1_q.size() > 0) && !map_wr && space;
        mrdy  = (s1_q.size() == 0) || adv;
        chk("req_ready", 64'(req_ready), 64'(mrdy));
        chk("out_valid", 64'(out_valid), 64'(out_q.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(out_q.size()));
        if (out_q.size() > 0)
            chk("head", 64'({out_addr, out_ems, out_we, out_be, out_wdata}), 64'(out_q[0]));
        if (s1_q.size() > 0)
            chk("memaddr", 64'(memaddr), 64'(s1_q[0].addr[19:14]));
        if (adv) begin
            r       = s1_q[0];
            e.addr  = (21'(map[r.addr[19:14]]) << 14) + 21'(r.addr[13:0]);
            e.ems   = map[r.addr[19:14]][6];
            e.we    = r.we;
            e.be    = r.be;
            e.wdata = r.wdata;
        end
        acc = req_valid && mrdy && !RST;
        if (pop && !RST) seen.push_back(out_addr);
        @(posedge CLK);
        if (RST) begin
            s1_q.delete();
            out_q.delete();
        end else begin
            if (pop) void'(out_q.pop_front());
            if (adv) begin
                void'(s1_q.pop_front());
                out_q.push_back(e);
            end
            if (acc) s1_q.push_back('{req_addr, req_we, req_be, req_wdata});
        end
        if (map_chg) map[chg_idx] = chg_val;
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [19:0] a, input logic we,
                             input logic [1:0] be, input logic [DATA_W-1:0] wd);
        req_valid = v;
        req_addr  = a;
        req_we    = we;
        req_be    = be;
        req_wdata = wd;
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        int          cyc;
        logic [19:0] bp_addr [4];

        for (int i = 0; i < 64; i++) map[i] = 7'(i);
        map_chg = 1'b0; chg_idx = 0; chg_val = '0;
        RST = 1'b1; map_wr = 1'b0; out_ready = 1'b1;
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);

        // Identity map
        drive_req(1'b1, 20'h12345, 1'b0, 2'b11, 16'h0000);
        step(acc);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        #2 chk("id_memaddr", 64'(memaddr), 64'h04);
        step(acc);
        #2;
        chk("id_valid", 64'(out_valid), 64'd1);
        chk("id_addr", 64'(out_addr), 64'h012345);
        chk("id_ems", 64'(out_ems), 64'd0);
        step(acc);

        // EMS window with write data
        map[6'h39] = 7'h45;
        drive_req(1'b1, 20'hE4010, 1'b1, 2'b01, 16'hBEEF);
        step(acc);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        step(acc);
        #2;
        chk("ems_addr", 64'(out_addr), 64'h114010);
        chk("ems_bit", 64'(out_ems), 64'd1);
        chk("ems_pass", 64'({out_we, out_be, out_wdata}), 64'({1'b1, 2'b01, 16'hBEEF}));
        step(acc);

        // Back-pressure: four back-to-back requests into a two-entry FIFO
        seen.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bp_addr[i] = 20'h01000 + 20'(i * 20'h04111);
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, bp_addr[i], 1'b0, 2'b11, 16'(i));
            step(acc);
        end
        drive_req(1'b1, bp_addr[3], 1'b0, 2'b11, 16'd3);
        #2;
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_ready", 64'(req_ready), 64'd0);
        step(acc);
        out_ready = 1'b1;
        cyc = 0;
        do begin
            step(acc);
            cyc++;
        end while (!acc && cyc < 20);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        repeat (6) step(acc);
        chk("bp_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("bp_order", 64'(seen[i]), 64'({map[bp_addr[i][19:14]], bp_addr[i][13:0]}));
        chk("bp_empty", 64'(occupancy), 64'd0);

        // Map-write hazard: lookup retried with the updated map
        map[6'h38] = 7'h40;
        drive_req(1'b1, 20'hE0000, 1'b0, 2'b11, 16'h0);
        step(acc);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        map_wr = 1'b1; map_chg = 1'b1; chg_idx = 6'h38; chg_val = 7'h41;
        #2 chk("hz_ready0", 64'(req_ready), 64'd0);
        step(acc);
        map_chg = 1'b0;
        #2 chk("hz_ready1", 64'(req_ready), 64'd0);
        step(acc);
        map_wr = 1'b0;
        step(acc);
        #2;
        chk("hz_addr", 64'(out_addr), 64'h104000);
        step(acc);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 20'h20000 + 20'(i), 1'b0, 2'b11, 16'(i));
            step(acc);
        end
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        RST = 1'b1;
        step(acc);
        RST = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_occ", 64'(occupancy), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd1);
        drive_req(1'b1, 20'h0ABCD, 1'b0, 2'b10, 16'h1234);
        step(acc);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        step(acc);
        #2 chk("mr_addr", 64'(out_addr), 64'h00ABCD);
        step(acc);

        // Random stress
        for (int i = 0; i < 64; i++) map[i] = 7'($urandom);
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            drive_req(($urandom_range(0, 9) < 7), 20'($urandom), 1'($urandom),
                      2'($urandom), DATA_W'($urandom));
            out_ready = ($urandom_range(0, 9) < 6);
            map_wr    = ($urandom_range(0, 99) < 15);
            map_chg   = map_wr;
            chg_idx   = ($urandom_range(0, 1) == 0) ? int'(memaddr) : int'($urandom_range(0, 63));
            chg_val   = 7'($urandom);
            step(acc);
            if (acc) n_acc++;
            cyc++;
        end
        chk("stress_acc", 64'(n_acc), 64'd10000);
        drive_req(1'b0, '0, 1'b0, 2'b00, '0);
        map_wr = 1'b0; map_chg = 1'b0; out_ready = 1'b1;
        repeat (8) step(acc);
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("drain_model", 64'(out_q.size() + s1_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_xlat_pipe.md
Name: seg_xlat_pipe

Overview:
- Downstream consumer of the segment/EMS mapper. It accepts 20-bit CPU memory requests and drives the mapper lookup index from each request.
- It combines the returned 7-bit physical page with the 14-bit page offset to form a 21-bit (2MB) physical address.
- Translated requests are buffered in a small FIFO and handed to the SDRAM/cache controller over a valid/ready handshake.
- A mapper register write is a hazard: any translation sampled in a cycle with a map write is discarded and redone.

Parameters:
- DATA_W, 16, width of write data carried alongside the request.
- OUT_DEPTH, 2, output FIFO entries; power of two, 2..8.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  request accepted on a CLK edge where req_valid & req_ready.
- req_addr  in  20  CPU linear address; A20 is not used (PCXT).
- req_we  in  1  1 = write, 0 = read.
- req_be  in  2  byte enables.
- req_wdata  in  DATA_W  write data.
- memaddr  out  6  to mapper; = s1_addr[19:14].
- memdata  in  7  from mapper, combinational; bit 6 set = EMS page.
- map_wr  in  1  OR of the mapper's WE and WE_EMS strobes for this cycle.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_addr  out  21  physical address = {page, offset[13:0]}.
- out_ems  out  1  page bit 6 of the translated entry.
- out_we  out  1  pass-through.
- out_be  out  2  pass-through.
- out_wdata  out  DATA_W  pass-through.
- occupancy  out  4  number of valid FIFO entries, 0..OUT_DEPTH.

Behaviour:
- Two stages:
  - S1: a registered request plus s1_valid.
  - OUT: a FIFO of OUT_DEPTH entries, each holding {addr21, ems, we, be, wdata}.
- Reset (RST high at an edge): s1_valid = 0, FIFO empty, wr/rd pointers = 0, occupancy = 0, out_valid = 0. req_ready is then 1 (combinational, S1 empty). Data registers may hold any value. Any in-flight or buffered requests are dropped.
- memaddr = s1_addr[19:14] at all times, including when S1 is empty.
- pop = out_valid & out_ready.
- space = (occupancy < OUT_DEPTH) | pop.
- adv = s1_valid & ~map_wr & space.
- On adv, S1 is written into the FIFO with:
  - addr21 = {memdata, s1_addr[13:0]}
  - ems = memdata[6]
- req_ready = ~s1_valid | adv. This is combinational from out_ready and map_wr; no registered path is required.
- Accept (req_valid & req_ready): S1 loads the request and s1_valid = 1. Otherwise, if adv, s1_valid = 0.
- Latency: request accepted at edge N → translated at edge N+1 → out_valid high after edge N+1, when the FIFO was empty and map_wr = 0 in cycle N+1. Each cycle of map_wr while S1 is valid adds one cycle.
- Map-write hazard: while map_wr = 1, S1 does not advance, because memdata may change at the next edge. The lookup repeats on the following cycle with the updated map. An entry already in the FIFO is never retranslated.
- Full: occupancy = OUT_DEPTH with no pop → S1 holds and req_ready = ~s1_valid.
- Simultaneous push and pop: occupancy is unchanged. Full with a pop allows a push in the same cycle.
- Empty FIFO: out_valid = 0 and out_* are don't-care. No bypass: an entry must be written before it can be popped.
- Order: strict FIFO; no reordering between reads and writes.
- Throughput: one request per cycle sustained when out_ready = 1 and map_wr = 0.
- Pointers are log2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH. occupancy is kept as a separate counter, incremented on push only and decremented on pop only.
- No combinational path from req_* to out_*.

Test Plan:
- Identity map: mapper models reset map; req_addr 0x12345 read → memaddr 0x04; memdata 0x04 → out_addr 0x012345, out_ems 0, out_valid the cycle after translation (latency 2 from accept).
- EMS window: req_addr 0xE4010, mapper returns 7'h45 → out_addr 0x114010, out_ems 1; write data 0xBEEF, be 2'b01 passed intact.
- Back-pressure (OUT_DEPTH 2, out_ready 0): 4 back-to-back requests → first two fill the FIFO (occupancy 2), third held in S1, req_ready 0 for the fourth. Raise out_ready → all four emerge in order, occupancy returns to 0, no duplicates or losses.
- Map hazard: S1 holds 0xE0000; map_wr = 1 for 2 cycles while the mapper output changes 0x40 → 0x41 → out_addr 0x104000, not 0x100000. req_ready stays 0 during map_wr.
- Reset mid-operation: FIFO holds 2 entries and S1 is valid; RST for 1 cycle → out_valid 0, occupancy 0, req_ready 1 on the next cycle; subsequent request translates normally.
- Random stress: 10k requests with random out_ready, map_wr and mapper contents against a scoreboard model (translation using the map value sampled on the non-map_wr advance cycle) → exact match, ordering preserved, occupancy never exceeds OUT_DEPTH.
